multi_buffer: RTL and testbench

MULTI_BUFFER -- requirements
Module: multi_buffer

---
 rtl/multi_buffer.sv | 159 +++++++++++++++
 tb/tb_multi_buffer.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_buffer.sv
// Double/triple frame buffer between a logic (producer) side and a render (consumer) side.
// Optional saturating dropped-frame counter enabled by defining MULTI_BUFFER_DROP_COUNT_EN.
module multi_buffer #(
  parameter int NUM_BUFS   = 3,
  parameter int ADDR_SIZE  = 12,
  parameter int LINE_WIDTH = 8,
  parameter int DROP_W     = 16
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  swap_in,
  input  logic                  frame_start_in,
  input  logic [ADDR_SIZE-1:0]  render_addr_r,
  input  logic [ADDR_SIZE-1:0]  logic_addr_r,
  input  logic [ADDR_SIZE-1:0]  logic_addr_w,
  input  logic [LINE_WIDTH-1:0] logic_data_w,
  input  logic                  logic_wr_en,
  output logic [LINE_WIDTH-1:0] render_data_r,
  output logic [LINE_WIDTH-1:0] logic_data_r,
  output logic                  logic_ready_out,
  output logic [1:0]            render_buf_out,
  output logic [DROP_W-1:0]     dropped_frames_out
);

  if (NUM_BUFS != 2 && NUM_BUFS != 3) begin : g_bad_num_bufs
    $error("multi_buffer: NUM_BUFS must be 2 or 3");
  end

  localparam bit TRIPLE = (NUM_BUFS == 3);
  localparam int BUF_W  = TRIPLE ? 2 : 1;
  localparam int MEM_AW = BUF_W + ADDR_SIZE;
  localparam int DEPTH  = NUM_BUFS * (1 << ADDR_SIZE);

  typedef enum logic {WRITING = 1'b0, WAIT_FREE = 1'b1} state_e;

  state_e          state_q, state_d;
  logic [1:0]      render_idx_q, render_idx_d;
  logic [1:0]      logic_idx_q, logic_idx_d;
  logic [1:0]      latest_idx_q, latest_idx_d;
  logic [1:0]      ready_idx_q, ready_idx_d;
  logic            ready_valid_q, ready_valid_d;
  logic [LINE_WIDTH-1:0] render_data_q, render_data_d;
  logic [LINE_WIDTH-1:0] logic_data_q, logic_data_d;

  logic [LINE_WIDTH-1:0] mem [DEPTH];
  logic [MEM_AW-1:0]     wr_addr, render_rd_addr, logic_rd_addr;
  logic                  swap_accept;

  // Buffer index occupies the upper address bits of one flat storage array.
  assign wr_addr        = {logic_idx_q[BUF_W-1:0], logic_addr_w};
  assign render_rd_addr = {render_idx_q[BUF_W-1:0], render_addr_r};
  assign logic_rd_addr  = {latest_idx_q[BUF_W-1:0], logic_addr_r};
  assign swap_accept    = swap_in && (state_q == WRITING);

  // NOTE: storage has no reset so it can map onto block RAM; only the read registers reset.
  always_ff @(posedge clk_in) begin
    if (logic_wr_en && state_q == WRITING) begin
      mem[wr_addr] <= logic_data_w;
    end
  end

  always_comb begin
    render_data_d = mem[render_rd_addr];
    logic_data_d  = mem[logic_rd_addr];
  end

  // NOTE: every sequential assignment is non-blocking so all flops sample pre-edge values.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q       <= WRITING;
      render_idx_q  <= 2'd0;
      logic_idx_q   <= 2'd1;
      latest_idx_q  <= 2'd0;
      ready_idx_q   <= 2'd0;
      ready_valid_q <= 1'b0;
      render_data_q <= '0;
      logic_data_q  <= '0;
    end else begin
      state_q       <= state_d;
      render_idx_q  <= render_idx_d;
      logic_idx_q   <= logic_idx_d;
      latest_idx_q  <= latest_idx_d;
      ready_idx_q   <= ready_idx_d;
      ready_valid_q <= ready_valid_d;
      render_data_q <= render_data_d;
      logic_data_q  <= logic_data_d;
    end
  end

  // NOTE: every signal gets a hold-value default first, so no path can infer a latch.
  always_comb begin
    state_d       = state_q;
    render_idx_d  = render_idx_q;
    logic_idx_d   = logic_idx_q;
    latest_idx_d  = latest_idx_q;
    ready_idx_d   = ready_idx_q;
    ready_valid_d = ready_valid_q;
    case (state_q)
      WRITING: begin
        // Frame start consumes the pre-edge ready buffer before any same-cycle publish.
        if (frame_start_in && ready_valid_q) begin
          render_idx_d  = ready_idx_q;
          ready_valid_d = 1'b0;
        end
        if (swap_in) begin
          ready_idx_d   = logic_idx_q;
          latest_idx_d  = logic_idx_q;
          ready_valid_d = 1'b1;
          if (TRIPLE) begin
            // Indices are 0,1,2, so the free one is 3 minus the two in use.
            logic_idx_d = 2'd3 - render_idx_d - logic_idx_q;
          end else begin
            state_d = WAIT_FREE;
          end
        end
      end
      WAIT_FREE: begin
        if (frame_start_in) begin
          render_idx_d  = ready_idx_q;
          ready_valid_d = 1'b0;
          logic_idx_d   = render_idx_q;
          state_d       = WRITING;
        end
      end
      default: state_d = WRITING;
    endcase
  end

  always_comb begin
    logic_ready_out = (state_q == WRITING);
    render_buf_out  = render_idx_q;
    render_data_r   = render_data_q;
    logic_data_r    = logic_data_q;
  end

`ifdef MULTI_BUFFER_DROP_COUNT_EN
  logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;

  // A publish overwrites an undisplayed frame unless the same edge's frame start takes it.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (swap_accept && ready_valid_q && !frame_start_in && drop_cnt_q != '1) begin
      drop_cnt_d = drop_cnt_q + DROP_W'(1);
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) drop_cnt_q <= '0;
    else        drop_cnt_q <= drop_cnt_d;
  end

  assign dropped_frames_out = drop_cnt_q;
`else
  logic unused_swap_accept;
  assign unused_swap_accept = swap_accept;
  assign dropped_frames_out = '0;
`endif

endmodule

// File: tb/tb_multi_buffer.sv
// Self-checking bench for multi_buffer: a 3-buffer and a 2-buffer instance share stimulus
// and are compared against a rule-level reference model plus hand-derived vectors.
module tb_multi_buffer;

  localparam int AW = 4;
  localparam int LW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          swap = 1'b0, fs = 1'b0, wr = 1'b0;
  logic [AW-1:0] waddr = '0, raddr = '0, laddr = '0;
  logic [LW-1:0] wdata = '0;

  logic [LW-1:0] rd3, ld3, rd2, ld2;
  logic          rdy3, rdy2;
  logic [1:0]    buf3, buf2;
  logic [1:0]    drop3;
  logic [15:0]   drop2;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  multi_buffer #(.NUM_BUFS(3), .ADDR_SIZE(AW), .LINE_WIDTH(LW), .DROP_W(2)) dut3 (
    .clk_in(clk), .rst_in(rst), .swap_in(swap), .frame_start_in(fs),
    .render_addr_r(raddr), .logic_addr_r(laddr), .logic_addr_w(waddr),
    .logic_data_w(wdata), .logic_wr_en(wr),
    .render_data_r(rd3), .logic_data_r(ld3), .logic_ready_out(rdy3),
    .render_buf_out(buf3), .dropped_frames_out(drop3));

  multi_buffer #(.NUM_BUFS(2), .ADDR_SIZE(AW), .LINE_WIDTH(LW), .DROP_W(16)) dut2 (
    .clk_in(clk), .rst_in(rst), .swap_in(swap), .frame_start_in(fs),
    .render_addr_r(raddr), .logic_addr_r(laddr), .logic_addr_w(waddr),
    .logic_data_w(wdata), .logic_wr_en(wr),
    .render_data_r(rd2), .logic_data_r(ld2), .logic_ready_out(rdy2),
    .render_buf_out(buf2), .dropped_frames_out(drop2));

  // Reference model, index 0 = 3-buffer instance, index 1 = 2-buffer instance.
  int          m_render[2], m_logic[2], m_latest[2], m_ready[2], m_drops[2];
  bit          m_rv[2], m_wait[2];
  logic [7:0]  m_mem[2][3][16];
  bit          m_known[2][3][16];
  logic [7:0]  e_rd[2], e_ld[2];
  bit          e_rd_ok[2], e_ld_ok[2];
  int          nb_of[2]    = '{3, 2};
  int          drop_max[2] = '{3, 65535};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic int exp_drop(input int k);
`ifdef MULTI_BUFFER_DROP_COUNT_EN
    return m_drops[k];
`else
    return 0 * k;
`endif
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_render[k] = 0; m_latest[k] = 0; m_logic[k] = 1; m_ready[k] = 0;
      m_rv[k] = 0; m_wait[k] = 0; m_drops[k] = 0;
    end
  endtask

  // Advance the model by one clock edge using the currently driven inputs.
  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      int n_render, n_logic, n_latest, n_ready;
      bit n_rv, n_wait;
      e_rd_ok[k] = m_known[k][m_render[k]][raddr];
      e_rd[k]    = m_mem[k][m_render[k]][raddr];
      e_ld_ok[k] = m_known[k][m_latest[k]][laddr];
      e_ld[k]    = m_mem[k][m_latest[k]][laddr];
      if (wr && !m_wait[k]) begin
        m_mem[k][m_logic[k]][waddr]   = wdata;
        m_known[k][m_logic[k]][waddr] = 1'b1;
      end
      n_render = m_render[k]; n_logic = m_logic[k]; n_latest = m_latest[k];
      n_ready = m_ready[k]; n_rv = m_rv[k]; n_wait = m_wait[k];
      if (!m_wait[k]) begin
        if (fs && m_rv[k]) begin
          n_render = m_ready[k];
          n_rv = 0;
        end
        if (swap) begin
          if (m_rv[k] && !fs && m_drops[k] < drop_max[k]) m_drops[k]++;
          n_ready = m_logic[k]; n_latest = m_logic[k]; n_rv = 1;
          if (nb_of[k] == 3) begin
            for (int b = 0; b < 3; b++)
              if (b != n_render && b != m_logic[k]) n_logic = b;
          end else begin
            n_wait = 1;
          end
        end
      end else if (fs) begin
        n_render = m_ready[k]; n_rv = 0; n_logic = m_render[k]; n_wait = 0;
      end
      m_render[k] = n_render; m_logic[k] = n_logic; m_latest[k] = n_latest;
      m_ready[k] = n_ready; m_rv[k] = n_rv; m_wait[k] = n_wait;
    end
  endtask

  task automatic drive(input bit s, input bit f, input bit w, input int wa, input int wd,
                       input int ra, input int la);
    swap = s; fs = f; wr = w;
    waddr = AW'(wa); wdata = LW'(wd); raddr = AW'(ra); laddr = AW'(la);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_checks(input string tag);
    check({tag, " buf3"},  32'(buf3),  32'd0);
    check({tag, " rdy3"},  32'(rdy3),  32'd1);
    check({tag, " rd3"},   32'(rd3),   32'd0);
    check({tag, " ld3"},   32'(ld3),   32'd0);
    check({tag, " drop3"}, 32'(drop3), 32'd0);
    check({tag, " buf2"},  32'(buf2),  32'd0);
    check({tag, " rdy2"},  32'(rdy2),  32'd1);
    check({tag, " drop2"}, 32'(drop2), 32'd0);
  endtask

  // Called #1 after a posedge; reset is checked before the next edge arrives.
  task automatic do_reset(input bit chk_async);
    drive(0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    #2;
    if (chk_async) reset_checks("async_rst");
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    reset_checks("post_rst");
  endtask

  task automatic cmp_model();
    check("rnd buf3", 32'(buf3), 32'(m_render[0]));
    check("rnd rdy3", 32'(rdy3), 32'(!m_wait[0]));
    check("rnd drop3", 32'(drop3), 32'(exp_drop(0)));
    if (e_rd_ok[0]) check("rnd rd3", 32'(rd3), 32'(e_rd[0]));
    if (e_ld_ok[0]) check("rnd ld3", 32'(ld3), 32'(e_ld[0]));
    check("rnd buf2", 32'(buf2), 32'(m_render[1]));
    check("rnd rdy2", 32'(rdy2), 32'(!m_wait[1]));
    check("rnd drop2", 32'(drop2), 32'(exp_drop(1)));
    if (e_rd_ok[1]) check("rnd rd2", 32'(rd2), 32'(e_rd[1]));
    if (e_ld_ok[1]) check("rnd ld2", 32'(ld2), 32'(e_ld[1]));
  endtask

  typedef struct {
    bit         swap, fs, wr;
    int         waddr, wdata, raddr, laddr;
    logic [1:0] e_buf;
    bit         e_rdy;
    bit         c_rd;
    logic [7:0] e_rd;
    bit         c_ld;
    logic [7:0] e_ld;
  } vec_t;

  vec_t tbl[10];

  initial begin
    // Hand-derived expectations for the 3-buffer instance starting from reset.
    tbl[0] = '{0, 0, 1, 5, 'hA5, 0, 0, 2'd0, 1, 0, 8'h00, 0, 8'h00};
    tbl[1] = '{1, 0, 0, 0, 0,     0, 5, 2'd0, 1, 0, 8'h00, 0, 8'h00};
    tbl[2] = '{0, 1, 0, 0, 0,     5, 5, 2'd1, 1, 0, 8'h00, 1, 8'hA5};
    tbl[3] = '{0, 0, 1, 5, 'h11,  5, 5, 2'd1, 1, 1, 8'hA5, 1, 8'hA5};
    tbl[4] = '{1, 0, 1, 6, 'h22,  5, 5, 2'd1, 1, 1, 8'hA5, 1, 8'hA5};
    tbl[5] = '{0, 0, 0, 0, 0,     5, 5, 2'd1, 1, 1, 8'hA5, 1, 8'h11};
    tbl[6] = '{1, 1, 0, 0, 0,     6, 6, 2'd2, 1, 0, 8'h00, 1, 8'h22};
    tbl[7] = '{0, 0, 0, 0, 0,     6, 6, 2'd2, 1, 1, 8'h22, 0, 8'h00};
    tbl[8] = '{0, 1, 0, 0, 0,     6, 0, 2'd0, 1, 1, 8'h22, 0, 8'h00};
    tbl[9] = '{0, 1, 0, 0, 0,     0, 0, 2'd0, 1, 0, 8'h00, 0, 8'h00};

    for (int k = 0; k < 2; k++)
      for (int b = 0; b < 3; b++)
        for (int a = 0; a < 16; a++) begin
          m_known[k][b][a] = 1'b0;
          m_mem[k][b][a]   = '0;
        end

    #1;
    do_reset(0);

    // Vector table: publish, display, read latency, same-cycle swap+frame_start.
    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].swap, tbl[i].fs, tbl[i].wr, tbl[i].waddr, tbl[i].wdata,
            tbl[i].raddr, tbl[i].laddr);
      tick();
      check($sformatf("vec%0d buf", i),  32'(buf3),  32'(tbl[i].e_buf));
      check($sformatf("vec%0d rdy", i),  32'(rdy3),  32'(tbl[i].e_rdy));
      check($sformatf("vec%0d drop", i), 32'(drop3), 32'd0);
      if (tbl[i].c_rd) check($sformatf("vec%0d rd", i), 32'(rd3), 32'(tbl[i].e_rd));
      if (tbl[i].c_ld) check($sformatf("vec%0d ld", i), 32'(ld3), 32'(tbl[i].e_ld));
    end

    // Two-buffer handshake: writes blocked while waiting, swap ignored, hand-back on frame.
    do_reset(0);
    drive(0, 0, 1, 3, 'h5A, 0, 0); tick();
    drive(1, 0, 0, 0, 0, 0, 0);    tick();
    check("nb2 wait rdy", 32'(rdy2), 32'd0);
    drive(0, 0, 1, 3, 'h3C, 0, 0); tick();
    check("nb2 drop wr rdy", 32'(rdy2), 32'd0);
    drive(1, 0, 0, 0, 0, 0, 0);    tick();
    check("nb2 ign swap buf", 32'(buf2), 32'd0);
    check("nb2 ign swap rdy", 32'(rdy2), 32'd0);
    drive(0, 1, 0, 0, 0, 0, 0);    tick();
    check("nb2 fs buf", 32'(buf2), 32'd1);
    check("nb2 fs rdy", 32'(rdy2), 32'd1);
    drive(0, 0, 0, 0, 0, 3, 0);    tick();
    check("nb2 kept data", 32'(rd2), 32'h5A);
    drive(0, 0, 1, 3, 'h77, 0, 0); tick();
    drive(1, 0, 0, 0, 0, 0, 0);    tick();
    drive(0, 0, 0, 0, 0, 0, 3);    tick();
    check("nb2 logic buf0", 32'(ld2), 32'h77);

    // Three publishes with no frame start: two overwritten frames.
    do_reset(0);
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 0, 0, 0, 0); tick();
    end
`ifdef MULTI_BUFFER_DROP_COUNT_EN
    check("drop3 after 3 swaps", 32'(drop3), 32'd2);
`else
    check("drop3 after 3 swaps", 32'(drop3), 32'd0);
`endif
    drive(0, 1, 0, 0, 0, 0, 0); tick();
    check("last published shown", 32'(buf3), 32'd1);

    // Pending ready buffer, then reset between edges.
    drive(1, 0, 0, 0, 0, 0, 0); tick();
    check("pre-reset buf3", 32'(buf3), 32'd1);
    do_reset(1);
    drive(0, 1, 0, 0, 0, 0, 0); tick();
    check("ready discarded buf3", 32'(buf3), 32'd0);

    // Randomized traffic against the reference model.
    for (int n = 0; n < 500; n++) begin
      drive($urandom_range(3) == 0, $urandom_range(4) == 0, $urandom_range(9) < 6,
            int'($urandom_range(15)), int'($urandom_range(255)),
            int'($urandom_range(15)), int'($urandom_range(15)));
      tick();
      cmp_model();
    end

    drive(0, 0, 0, 0, 0, 0, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
